// File: rtl/posit_accum_mc.sv
`default_nettype none
// ==========================================================================
// posit_accum_mc : multi-channel posit accumulator, exact quire per channel
// Rev 1.0
// ==========================================================================
module posit_accum_mc #(
  parameter int  NBITS    = 32,
  parameter int  ES       = 2,
  parameter int  CHANNELS = 4,
  parameter int  GUARD    = 8,
  localparam int CW       = $clog2(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic [CW-1:0]    in_chan,
  input  logic             in_first,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic [CW-1:0]    out_chan,
  output logic             out_inf,
  output logic             out_zero
);

  localparam int MAXS  = (NBITS - 2) * (2 ** ES);
  localparam int QFRAC = MAXS + NBITS;
  localparam int QBITS = QFRAC + MAXS + 1 + GUARD + 1;
  localparam int PW    = $clog2(QBITS);
  localparam int SCW   = PW + 2;
  localparam int RW    = $clog2(NBITS) + 1;
  localparam int VW    = 2 * NBITS + ES + 2;
  localparam logic signed [SCW-1:0] SMAX = SCW'(MAXS);
  localparam logic signed [SCW-1:0] SMIN = -SCW'(MAXS);
  localparam logic [NBITS-1:0]      NAR  = {1'b1, {(NBITS-1){1'b0}}};

  logic             out_valid_q, out_inf_q, out_zero_q;
  logic [NBITS-1:0] out_data_q;
  logic [CW-1:0]    out_chan_q;
  logic             adv;

  assign in_ready  = ~out_valid_q | out_ready;
  assign adv       = in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;
  assign out_inf   = out_inf_q;
  assign out_zero  = out_zero_q;

  // E0: input register
  logic             s0_valid_q, s0_first_q, s0_last_q;
  logic [NBITS-1:0] s0_data_q;
  logic [CW-1:0]    s0_chan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q <= 1'b0;
      s0_first_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_data_q  <= '0;
      s0_chan_q  <= '0;
    end else if (adv) begin
      s0_valid_q <= in_valid;
      s0_first_q <= in_first;
      s0_last_q  <= in_last;
      s0_data_q  <= in_data;
      s0_chan_q  <= in_chan;
    end
  end

  // E1: decode and align onto the quire grid
  logic                  dec_sign, dec_rbit, dec_done, s1_nar_d;
  logic [NBITS-2:0]      dec_rem, dec_sh;
  logic [NBITS-1:0]      dec_mant;
  logic [RW-1:0]         dec_run;
  logic [ES-1:0]         dec_exp;
  logic signed [SCW-1:0] dec_k, dec_scale;
  logic [PW-1:0]         dec_shamt;
  logic [QBITS-1:0]      dec_mag, s1_term_d;

  always_comb begin
    dec_sign = s0_data_q[NBITS-1];
    dec_rem  = dec_sign ? -s0_data_q[NBITS-2:0] : s0_data_q[NBITS-2:0];
    dec_rbit = dec_rem[NBITS-2];
    dec_run  = '0;
    dec_done = 1'b0;
    for (int i = NBITS - 2; i >= 0; i--) begin
      if (!dec_done && (dec_rem[i] == dec_rbit)) dec_run = dec_run + RW'(1);
      else dec_done = 1'b1;
    end
    dec_sh    = dec_rem << (dec_run + RW'(1));
    dec_exp   = dec_sh[NBITS-2 -: ES];
    dec_mant  = {1'b1, dec_sh << ES};
    dec_k     = dec_rbit ? (SCW'(dec_run) - SCW'(1)) : -SCW'(dec_run);
    dec_scale = (dec_k << ES) + SCW'(dec_exp);
    // hidden one lands at bit scale+QFRAC, so the shift is never negative
    dec_shamt = PW'(dec_scale + SCW'(MAXS + 1));
    dec_mag   = QBITS'(dec_mant) << dec_shamt;
    s1_nar_d  = (s0_data_q == NAR);
    if ((s0_data_q == '0) || s1_nar_d) s1_term_d = '0;
    else                                s1_term_d = dec_sign ? -dec_mag : dec_mag;
  end

  logic             s1_valid_q, s1_first_q, s1_last_q, s1_nar_q;
  logic [QBITS-1:0] s1_term_q;
  logic [CW-1:0]    s1_chan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_nar_q   <= 1'b0;
      s1_term_q  <= '0;
      s1_chan_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= s0_valid_q;
      s1_first_q <= s0_first_q;
      s1_last_q  <= s0_last_q;
      s1_nar_q   <= s1_nar_d;
      s1_term_q  <= s1_term_d;
      s1_chan_q  <= s0_chan_q;
    end
  end

  // E2: quire read-modify-write, one term per cycle per channel
  logic [QBITS-1:0] quire_q [CHANNELS];
  logic             nar_q   [CHANNELS];
  logic             ovf_q   [CHANNELS];
  logic [QBITS-1:0] rmw_old, rmw_sum, q_new_d;
  logic             rmw_ovf, nar_new_d, ovf_new_d;

  always_comb begin
    rmw_old = quire_q[s1_chan_q];
    rmw_sum = rmw_old + s1_term_q;
    rmw_ovf = (rmw_old[QBITS-1] == s1_term_q[QBITS-1]) &&
              (rmw_sum[QBITS-1] != rmw_old[QBITS-1]);
    if (s1_first_q) begin
      q_new_d   = s1_term_q;
      nar_new_d = s1_nar_q;
      ovf_new_d = 1'b0;
    end else begin
      q_new_d   = rmw_sum;
      nar_new_d = nar_q[s1_chan_q] | s1_nar_q;
      ovf_new_d = ovf_q[s1_chan_q] | rmw_ovf;
    end
  end

  genvar gc;
  generate
    for (gc = 0; gc < CHANNELS; gc++) begin : g_chan
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          quire_q[gc] <= '0;
          nar_q[gc]   <= 1'b0;
          ovf_q[gc]   <= 1'b0;
        end else if (adv && s1_valid_q && (s1_chan_q == CW'(gc))) begin
          quire_q[gc] <= q_new_d;
          nar_q[gc]   <= nar_new_d;
          ovf_q[gc]   <= ovf_new_d;
        end
      end
    end
  endgenerate

  logic             s2_valid_q, s2_inf_q;
  logic [QBITS-1:0] s2_sum_q;
  logic [CW-1:0]    s2_chan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_sum_q   <= '0;
      s2_chan_q  <= '0;
    end else if (adv) begin
      s2_valid_q <= s1_valid_q & s1_last_q;
      s2_inf_q   <= nar_new_d | ovf_new_d;
      s2_sum_q   <= q_new_d;
      s2_chan_q  <= s1_chan_q;
    end
  end

  // E3: leading-one detect and normalise
  logic                  nrm_sign, s3_sticky_d, s3_zero_d;
  logic [QBITS-1:0]      nrm_mag, nrm_norm;
  logic [PW-1:0]         nrm_pos;
  logic [NBITS-1:0]      s3_frac_d;
  logic signed [SCW-1:0] s3_scale_d;

  always_comb begin
    nrm_sign = s2_sum_q[QBITS-1];
    nrm_mag  = nrm_sign ? -s2_sum_q : s2_sum_q;
    nrm_pos  = '0;
    for (int i = 0; i < QBITS; i++) begin
      if (nrm_mag[i]) nrm_pos = PW'(i);
    end
    nrm_norm    = nrm_mag << (PW'(QBITS - 1) - nrm_pos);
    s3_frac_d   = nrm_norm[QBITS-2 -: NBITS];
    s3_sticky_d = |nrm_norm[QBITS-NBITS-2:0];
    s3_scale_d  = SCW'(nrm_pos) - SCW'(QFRAC);
    s3_zero_d   = ~nrm_norm[QBITS-1] & ~s2_inf_q;
  end

  logic                  s3_valid_q, s3_sign_q, s3_sticky_q, s3_zero_q, s3_inf_q;
  logic [NBITS-1:0]      s3_frac_q;
  logic signed [SCW-1:0] s3_scale_q;
  logic [CW-1:0]         s3_chan_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid_q  <= 1'b0;
      s3_sign_q   <= 1'b0;
      s3_sticky_q <= 1'b0;
      s3_zero_q   <= 1'b0;
      s3_inf_q    <= 1'b0;
      s3_frac_q   <= '0;
      s3_scale_q  <= '0;
      s3_chan_q   <= '0;
    end else if (adv) begin
      s3_valid_q  <= s2_valid_q;
      s3_sign_q   <= nrm_sign;
      s3_sticky_q <= s3_sticky_d;
      s3_zero_q   <= s3_zero_d;
      s3_inf_q    <= s2_inf_q;
      s3_frac_q   <= s3_frac_d;
      s3_scale_q  <= s3_scale_d;
      s3_chan_q   <= s2_chan_q;
    end
  end

  // E4: pack regime/exponent/fraction, round to nearest even
  logic signed [SCW-1:0] pk_scale, pk_k;
  logic [NBITS-1:0]      pk_frac, pk_mag, out_data_d;
  logic                  pk_stin, pk_rb, pk_st, pk_inc;
  logic signed [VW-1:0]  pk_raw, pk_vec;
  logic [NBITS-2:0]      pk_body;

  always_comb begin
    pk_scale = s3_scale_q;
    pk_frac  = s3_frac_q;
    pk_stin  = s3_sticky_q;
    if (s3_scale_q > SMAX) begin
      pk_scale = SMAX;
      pk_frac  = '0;
      pk_stin  = 1'b0;
    end else if (s3_scale_q < SMIN) begin
      pk_scale = SMIN;
      pk_frac  = '0;
      pk_stin  = 1'b0;
    end
    pk_k   = pk_scale >>> ES;
    // seed "10" (k>=0) or "01" (k<0); arithmetic shift replicates the run bit
    pk_raw = {~pk_k[SCW-1], pk_k[SCW-1], pk_scale[ES-1:0], pk_frac, {NBITS{1'b0}}};
    pk_vec = pk_raw >>> (pk_k[SCW-1] ? ~pk_k : pk_k);
    pk_body = pk_vec[VW-1 -: NBITS-1];
    pk_rb   = pk_vec[VW-NBITS];
    pk_st   = (|pk_vec[VW-NBITS-1:0]) | pk_stin;
    pk_inc  = pk_rb & (pk_st | pk_body[0]);
    pk_mag  = {1'b0, pk_body} + NBITS'(pk_inc);
    if (s3_inf_q)       out_data_d = NAR;
    else if (s3_zero_q) out_data_d = '0;
    else                out_data_d = s3_sign_q ? -pk_mag : pk_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_inf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else if (adv) begin
      out_valid_q <= s3_valid_q;
      if (s3_valid_q) begin
        out_data_q <= out_data_d;
        out_chan_q <= s3_chan_q;
        out_inf_q  <= s3_inf_q;
        out_zero_q <= s3_zero_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_accum_mc.sv
`default_nettype none
// Directed bench for posit_accum_mc: expectations queued at issue, checked by a monitor.
module tb_posit_accum_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_first, in_last;
  logic [31:0] in_data;
  logic [1:0]  in_chan;
  logic        out_valid, out_ready, out_inf, out_zero;
  logic [31:0] out_data;
  logic [1:0]  out_chan;

  always #5 clk = ~clk;

  posit_accum_mc #(
    .NBITS(32), .ES(2), .CHANNELS(4), .GUARD(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
    .in_first(in_first), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .out_inf(out_inf), .out_zero(out_zero)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  ch;
    logic        inf;
    logic        zero;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Present one term; returns one cycle after it is accepted.
  task automatic send(input logic [1:0] ch, input logic [31:0] d, input logic f, input logic l,
                      input logic [31:0] ed, input logic einf, input logic ezero, input logic push);
    int   n;
    logic acc;
    exp_t e;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_chan = ch; in_first = f; in_last = l;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout chan=%0d data=%h", ch, d);
    end else if (l && push) begin
      e.d = ed; e.ch = ch; e.inf = einf; e.zero = ezero;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d", sb.size());
    end
  endtask

  // Monitor: one comparison per result transfer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_result got data=%h chan=%0d", out_data, out_chan);
        end else begin
          e = sb.pop_front();
          if (out_data !== e.d || out_chan !== e.ch || out_inf !== e.inf || out_zero !== e.zero) begin
            failures++;
            $display("FAIL result got data=%h chan=%0d inf=%b zero=%b want data=%h chan=%0d inf=%b zero=%b",
                     out_data, out_chan, out_inf, out_zero, e.d, e.ch, e.inf, e.zero);
          end
        end
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_chan = '0;
    in_first = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  out_data,        32'd0);
    chk("rst_out_flags", {28'd0, out_chan, out_inf, out_zero}, 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1 + 2 = 3, with latency measured from the last accept
    send(2'd0, 32'h40000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd0, 32'h48000000, 1'b0, 1'b1, 32'h4C000000, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    drain();

    // interleaved channels, back-to-back same-channel terms
    send(2'd1, 32'h40000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd1, 32'h40000000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd2, 32'hC0000000, 1'b1, 1'b1, 32'hC0000000, 1'b0, 1'b0, 1'b1);
    send(2'd1, 32'h40000000, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd1, 32'h40000000, 1'b0, 1'b1, 32'h50000000, 1'b0, 1'b0, 1'b1);
    // -1 + -2 = -3
    send(2'd2, 32'hC0000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd2, 32'hB8000000, 1'b0, 1'b1, 32'hB4000000, 1'b0, 1'b0, 1'b1);
    // exact cancellation, minpos identity, tiny addend rounds away
    send(2'd0, 32'h40000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd0, 32'hC0000000, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1, 1'b1);
    send(2'd3, 32'h00000001, 1'b1, 1'b1, 32'h00000001, 1'b0, 1'b0, 1'b1);
    send(2'd1, 32'h40000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd1, 32'h00000001, 1'b0, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b1);
    // NaR is sticky until the next first term
    send(2'd3, 32'h80000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd3, 32'h40000000, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b0, 1'b1);
    send(2'd3, 32'h40000000, 1'b1, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b1);
    drain();

    // maxpos + maxpos saturates; consumer stalled while result waits
    out_ready = 1'b0;
    send(2'd0, 32'h7FFFFFFF, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd0, 32'h7FFFFFFF, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_in_ready",  32'(in_ready),  32'd0);
      chk("stall_out_data",  out_data,        32'h7FFFFFFF);
    end
    out_ready = 1'b1;
    drain();

    // reset mid-accumulation drops the in-flight result and clears the quire
    send(2'd0, 32'h40000000, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    send(2'd0, 32'h40000000, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready",  32'(in_ready),  32'd1);
    chk("midrst_out_data",  out_data,        32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("postrst_no_result", 32'(out_valid), 32'd0);
    send(2'd0, 32'h40000000, 1'b0, 1'b1, 32'h40000000, 1'b0, 1'b0, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
